maze_path_ctrl: RTL and testbench

MAZE_PATH_CTRL -- requirements
Module: maze_path_ctrl

---
 rtl/maze_pkg.sv | 35 +++
 rtl/path_stack.sv | 73 +++++++
 rtl/maze_path_ctrl.sv | 167 ++++++++++++++++
 tb/tb_maze_path_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared states, direction codes and move arithmetic for the maze path controller
package maze_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_SOLVED = 3'd2,
        ST_REPLAY = 3'd3,
        ST_END    = 3'd4,
        ST_FAILED = 3'd5
    } state_e;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam int DEPTH_DEFAULT = 256;

    // Position is {row, col}; both nibbles wrap modulo 16.
    function automatic logic [7:0] apply_dir(input logic [7:0] pos, input logic [1:0] dir);
        logic [3:0] row;
        logic [3:0] col;
        row = pos[7:4];
        col = pos[3:0];
        case (dir)
            DIR_UP:    row = row - 4'd1;
            DIR_RIGHT: col = col + 4'd1;
            DIR_DOWN:  row = row + 4'd1;
            default:   col = col - 4'd1;
        endcase
        return {row, col};
    endfunction

endpackage

// File: rtl/path_stack.sv
// rtl/path_stack.sv - 2-bit path stack with push, pop, replace-top and indexed async read
module path_stack
    import maze_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [1:0]    rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [1:0]    mem_q [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_idx];

    // Push+pop together overwrites the top entry; illegal operations are dropped here as well.
    always_comb begin
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = count_q[AW-1:0];
        if (clear) begin
            count_d = '0;
        end else if (push && pop) begin
            if (!empty) begin
                wr_en   = 1'b1;
                wr_addr = AW'(count_q - 1'b1);
            end
        end else if (push) begin
            if (!full) begin
                wr_en   = 1'b1;
                count_d = count_q + 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Stack storage; contents survive reset, only the count is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Entry count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/maze_path_ctrl.sv
// rtl/maze_path_ctrl.sv - maze search/replay controller: FSM, step timer and position tracking
module maze_path_ctrl
    import maze_pkg::*;
#(
    parameter int STEP_CYCLES = 1,
    parameter int DEPTH       = DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Start,
    input  logic       Run,
    input  logic       step_valid,
    input  logic [1:0] step_dir,
    input  logic       step_pop,
    input  logic       solver_done,
    input  logic       solver_fail,
    output logic       solver_go,
    output logic       Fail,
    output logic       Done,
    output logic       The_End,
    output logic [7:0] Move
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] index_q;
    logic [CW-1:0] index_d;
    logic [7:0]    step_q;
    logic [7:0]    step_d;
    logic [7:0]    move_q;
    logic [7:0]    move_d;
    logic          go_q;
    logic          go_d;
    logic          fail_q;
    logic          done_q;
    logic          the_end_q;

    logic          stk_clear;
    logic          stk_push;
    logic          stk_pop;
    logic [1:0]    stk_rd_data;
    logic [CW-1:0] stk_count;
    logic          stk_full;
    logic          stk_empty;
    logic          overflow;
    logic          underflow;

    path_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst),
        .clear   (stk_clear),
        .push    (stk_push),
        .pop     (stk_pop),
        .wr_data (step_dir),
        .rd_idx  (index_q[AW-1:0]),
        .rd_data (stk_rd_data),
        .count   (stk_count),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    // A lone push needs room; any pop (including replace) needs an entry.
    assign overflow  = step_valid && !step_pop && stk_full;
    assign underflow = step_pop && stk_empty;

    // Next-state, stack control and replay position.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        step_d    = step_q;
        move_d    = move_q;
        go_d      = 1'b0;
        stk_clear = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        case (state_q)
            ST_IDLE, ST_END, ST_FAILED: begin
                if (Start) begin
                    state_d   = ST_SEARCH;
                    go_d      = 1'b1;
                    stk_clear = 1'b1;
                    index_d   = '0;
                    step_d    = '0;
                    move_d    = 8'h00;
                end
            end
            ST_SEARCH: begin
                if (overflow || underflow) begin
                    state_d = ST_FAILED;
                end else begin
                    stk_push = step_valid;
                    stk_pop  = step_pop;
                    if (solver_fail) begin
                        state_d = ST_FAILED;
                    end else if (solver_done) begin
                        state_d = ST_SOLVED;
                    end
                end
            end
            ST_SOLVED: begin
                if (Run) begin
                    state_d = ST_REPLAY;
                    index_d = '0;
                    step_d  = '0;
                    move_d  = 8'h00;
                end
            end
            ST_REPLAY: begin
                if (index_q == stk_count) begin
                    state_d = ST_END;
                end else if (step_q == STEP_LAST) begin
                    move_d  = apply_dir(move_q, stk_rd_data);
                    index_d = index_q + 1'b1;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, replay index, step timer and position registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            step_q  <= '0;
            move_q  <= 8'h00;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            step_q  <= step_d;
            move_q  <= move_d;
            go_q    <= go_d;
        end
    end

    // Status flags registered from the next state so they line up with the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_q    <= 1'b0;
            done_q    <= 1'b0;
            the_end_q <= 1'b0;
        end else begin
            fail_q    <= (state_d == ST_FAILED);
            done_q    <= (state_d == ST_SOLVED) || (state_d == ST_REPLAY) || (state_d == ST_END);
            the_end_q <= (state_d == ST_END);
        end
    end

    assign solver_go = go_q;
    assign Fail      = fail_q;
    assign Done      = done_q;
    assign The_End   = the_end_q;
    assign Move      = move_q;

endmodule

// File: tb/tb_maze_path_ctrl.sv
// tb/tb_maze_path_ctrl.sv - directed self-checking bench for maze_path_ctrl
module tb_maze_path_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       run;
    logic       step_valid;
    logic [1:0] step_dir;
    logic       step_pop;
    logic       solver_done;
    logic       solver_fail;

    logic       go;
    logic       fail;
    logic       done;
    logic       the_end;
    logic [7:0] move;

    logic       go4;
    logic       fail4;
    logic       done4;
    logic       the_end4;
    logic [7:0] move4;

    int n_checks;
    int n_errors;

    maze_path_ctrl #(
        .STEP_CYCLES (1),
        .DEPTH       (256)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .Start       (start),
        .Run         (run),
        .step_valid  (step_valid),
        .step_dir    (step_dir),
        .step_pop    (step_pop),
        .solver_done (solver_done),
        .solver_fail (solver_fail),
        .solver_go   (go),
        .Fail        (fail),
        .Done        (done),
        .The_End     (the_end),
        .Move        (move)
    );

    maze_path_ctrl #(
        .STEP_CYCLES (4),
        .DEPTH       (256)
    ) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .Start       (start),
        .Run         (run),
        .step_valid  (step_valid),
        .step_dir    (step_dir),
        .step_pop    (step_pop),
        .solver_done (solver_done),
        .solver_fail (solver_fail),
        .solver_go   (go4),
        .Fail        (fail4),
        .Done        (done4),
        .The_End     (the_end4),
        .Move        (move4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] d);
        step_valid = 1'b1;
        step_dir   = d;
        tick();
        step_valid = 1'b0;
    endtask

    task automatic start_search(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_go_hi"}, go, 1);
        tick();
        check({tag, "_go_lo"}, go, 0);
    endtask

    task automatic solve_and_run();
        solver_done = 1'b1;
        tick();
        solver_done = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b0;
        start       = 1'b0;
        run         = 1'b0;
        step_valid  = 1'b0;
        step_dir    = 2'b00;
        step_pop    = 1'b0;
        solver_done = 1'b0;
        solver_fail = 1'b0;

        #12;
        check("rst_go", go, 0);
        check("rst_fail", fail, 0);
        check("rst_done", done, 0);
        check("rst_end", the_end, 0);
        check("rst_move", move, 8'h00);
        tick();
        rst = 1'b1;
        tick();

        // Path right, right, down replayed one move per cycle.
        start_search("t1");
        push(2'b01);
        push(2'b01);
        push(2'b10);
        solver_done = 1'b1;
        tick();
        solver_done = 1'b0;
        check("t1_done", done, 1);
        check("t1_end0", the_end, 0);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("t1_m0", move, 8'h00);
        tick();
        check("t1_m1", move, 8'h01);
        tick();
        check("t1_m2", move, 8'h02);
        tick();
        check("t1_m3", move, 8'h12);
        tick();
        check("t1_end", the_end, 1);
        check("t1_done_end", done, 1);
        check("t1_hold", move, 8'h12);

        // Wrap on both fields: up then left from origin.
        start_search("t2");
        check("t2_done_clr", done, 0);
        check("t2_end_clr", the_end, 0);
        push(2'b00);
        push(2'b11);
        solve_and_run();
        check("t2_m0", move, 8'h00);
        tick();
        check("t2_m1", move, 8'hF0);
        tick();
        check("t2_m2", move, 8'hFF);
        tick();
        check("t2_end", the_end, 1);

        // Pop then replace-top leaves a single left move.
        start_search("t3");
        push(2'b01);
        push(2'b10);
        step_pop = 1'b1;
        tick();
        step_pop   = 1'b0;
        step_valid = 1'b1;
        step_pop   = 1'b1;
        step_dir   = 2'b11;
        tick();
        step_valid = 1'b0;
        step_pop   = 1'b0;
        check("t3_fail", fail, 0);
        solve_and_run();
        check("t3_m0", move, 8'h00);
        tick();
        check("t3_m1", move, 8'h0F);
        tick();
        check("t3_end", the_end, 1);
        check("t3_hold", move, 8'h0F);

        // Fail and done together: fail wins, Run is ignored.
        start_search("t4");
        push(2'b01);
        solver_done = 1'b1;
        solver_fail = 1'b1;
        tick();
        solver_done = 1'b0;
        solver_fail = 1'b0;
        check("t4_fail", fail, 1);
        check("t4_done", done, 0);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        check("t4_move", move, 8'h00);
        check("t4_fail_hold", fail, 1);
        check("t4_end", the_end, 0);

        // Overflow on the 257th push, underflow on pop at empty.
        start_search("t5");
        check("t5_fail_clr", fail, 0);
        for (int i = 0; i < 256; i++) begin
            push(2'(i));
        end
        check("t5_full_ok", fail, 0);
        push(2'b01);
        check("t5_ovf", fail, 1);
        start_search("t5b");
        check("t5b_fail_clr", fail, 0);
        step_pop = 1'b1;
        tick();
        step_pop = 1'b0;
        check("t5_udf", fail, 1);
        check("t5_udf_done", done, 0);

        // Empty path goes straight to END at origin.
        start_search("t6");
        solve_and_run();
        check("t6_m0", move, 8'h00);
        tick();
        check("t6_end", the_end, 1);
        check("t6_move", move, 8'h00);

        // Resynchronise both instances, then slow replay and mid-replay reset.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t7_go4_hi", go4, 1);
        tick();
        check("t7_go4_lo", go4, 0);
        push(2'b01);
        push(2'b01);
        solve_and_run();
        check("t7_m0", move4, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t7_wait", move4, 8'h00);
        end
        tick();
        check("t7_m1", move4, 8'h01);
        tick();
        tick();
        check("t7_mid_done", done4, 1);
        #3;
        rst = 1'b0;
        #1;
        check("t7_rst_go", go4, 0);
        check("t7_rst_fail", fail4, 0);
        check("t7_rst_done", done4, 0);
        check("t7_rst_end", the_end4, 0);
        check("t7_rst_move", move4, 8'h00);
        check("t7_rst_move1", move, 8'h00);
        rst = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t7_go_hi", go4, 1);
        tick();
        check("t7_go_lo", go4, 0);
        solve_and_run();
        tick();
        check("t7_empty_end", the_end4, 1);
        check("t7_empty_move", move4, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
